// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS-subset core with one shared word-addressed memory port (req/ready).
// Sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with an absorbing HALT state.
module mips_multicycle_cpu #(
    parameter int unsigned         DATA_W   = 32,
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal
);

    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StHalt   = 3'd5;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc, pc1;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a, b, aluout, mdr;
    logic [DATA_W-1:0] regs [32];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] imm_ext, rs_val, rt_val, alu_res;
    logic [ADDR_W-1:0] br_target, jtarget, npc;
    logic              legal, is_jump;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              unused_shamt;

    assign op           = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign unused_shamt = ^ir[10:6];
    assign imm_ext      = DATA_W'($signed(ir[15:0]));
    assign rs_val       = (rs == 5'd0) ? '0 : regs[rs];
    assign rt_val       = (rt == 5'd0) ? '0 : regs[rt];
    assign br_target    = pc1 + ADDR_W'(imm_ext);

    if (ADDR_W > 26) begin : g_jt_wide
        assign jtarget = {pc1[ADDR_W-1:26], ir[25:0]};
    end else begin : g_jt_narrow
        assign jtarget = ir[ADDR_W-1:0];
    end

    assign pc_out = pc;
    assign halted = (state == StHalt);

    always_comb begin
        legal = 1'b0;
        case (op)
            OpRtype: begin
                case (funct)
                    FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnJr: legal = 1'b1;
                    default: legal = 1'b0;
                endcase
            end
            OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ, OpJal, OpHalt: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = a + imm_ext;
        if (op == OpRtype) begin
            case (funct)
                FnSub:   alu_res = a - b;
                FnAnd:   alu_res = a & b;
                FnOr:    alu_res = a | b;
                FnSlt:   alu_res = DATA_W'($signed(a) < $signed(b));
                default: alu_res = a + b;
            endcase
        end
    end

    // Control transfers resolve in EXEC and go straight back to FETCH.
    always_comb begin
        is_jump = 1'b0;
        npc     = pc1;
        case (op)
            OpBeq: begin
                is_jump = 1'b1;
                npc     = (a == b) ? br_target : pc1;
            end
            OpBne: begin
                is_jump = 1'b1;
                npc     = (a != b) ? br_target : pc1;
            end
            OpJ, OpJal: begin
                is_jump = 1'b1;
                npc     = jtarget;
            end
            OpRtype: begin
                if (funct == FnJr) begin
                    is_jump = 1'b1;
                    npc     = ADDR_W'(a);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = aluout;
        if (state == StWb) begin
            rf_we    = 1'b1;
            rf_waddr = (op == OpRtype) ? rd : rt;
            rf_wdata = (op == OpLw) ? mdr : aluout;
        end else if (state == StExec && op == OpJal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = DATA_W'(pc1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    // Memory request lines are registered; every path into FETCH/MEM loads them together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StFetch;
            pc        <= RESET_PC;
            pc1       <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            aluout    <= '0;
            mdr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= RESET_PC;
            mem_wdata <= '0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                StFetch: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ready) begin
                        ir      <= 32'(mem_rdata);
                        pc1     <= pc + ADDR_W'(1);
                        mem_req <= 1'b0;
                        state   <= StDecode;
                    end
                end
                StDecode: begin
                    a <= rs_val;
                    b <= rt_val;
                    if (!legal) begin
                        illegal <= 1'b1;
                        state   <= StHalt;
                    end else if (op == OpHalt) begin
                        state <= StHalt;
                    end else begin
                        state <= StExec;
                    end
                end
                StExec: begin
                    aluout <= alu_res;
                    if (is_jump) begin
                        pc       <= npc;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= npc;
                        state    <= StFetch;
                    end else if (op == OpLw || op == OpSw) begin
                        mem_req   <= 1'b1;
                        mem_we    <= (op == OpSw);
                        mem_addr  <= ADDR_W'(alu_res);
                        mem_wdata <= b;
                        state     <= StMem;
                    end else begin
                        state <= StWb;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (op == OpLw) begin
                            mdr     <= mem_rdata;
                            mem_req <= 1'b0;
                            state   <= StWb;
                        end else begin
                            pc       <= pc1;
                            mem_addr <= pc1;
                            state    <= StFetch;
                        end
                    end
                end
                StWb: begin
                    pc       <= pc1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc1;
                    state    <= StFetch;
                end
                default: state <= StHalt;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed bench for mips_multicycle_cpu: table of single-instruction programs plus
// hand-written sequences for wait states, loops, jal/jr, illegal opcodes and mid-access reset.
module tb_mips_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, mem_ready, halted, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

    mips_multicycle_cpu #(.DATA_W(32), .ADDR_W(32), .RESET_PC(32'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc_out    (pc_out),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Memory model with a programmable number of wait cycles per access.
    logic [31:0] mem [0:255];
    int          cnt = 0;
    int          wait_cycles = 0;
    int          wr_count = 0;
    int          viol = 0;
    int          fetch10 = 0;
    logic        saw40 = 1'b0;
    logic        prev_chk = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    assign mem_ready = mem_req && (cnt >= wait_cycles);
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (!rst_n || !mem_req || mem_ready) cnt <= 0;
        else cnt <= cnt + 1;
        if (rst_n && mem_req && mem_ready && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (rst_n && mem_req && mem_ready && !mem_we && mem_addr == 32'h40) saw40 <= 1'b1;
        if (rst_n && mem_req && mem_ready && !mem_we && mem_addr == 32'd10) fetch10 <= fetch10 + 1;
        if (rst_n && prev_chk &&
            (!mem_req || mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
            viol <= viol + 1;
        prev_chk   <= rst_n && mem_req && !mem_ready;
        prev_addr  <= mem_addr;
        prev_we    <= mem_we;
        prev_wdata <= mem_wdata;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic logic [31:0] rf(input int idx);
        return dut.regs[idx];
    endfunction

    localparam logic [31:0] Halt = 32'hFC00_0000;

    // Holds reset and clears memory; caller then loads its program.
    task automatic start_reset();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) mem[i] <= Halt;
        wr_count <= 0;
        viol     <= 0;
        saw40    <= 1'b0;
        fetch10  <= 0;
    endtask

    task automatic run(input int wait_n, input int max_cycles, output int cycles);
        wait_cycles = wait_n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cycles = 0;
        while (!halted && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
        end
        check("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] instr;
        int          reg_idx;
        logic [31:0] exp_val;
        int          exp_cycles;
        logic [31:0] exp_pc;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[14];
    int   cyc;

    initial begin
        // Program per vector: addi $1,$0,5; addi $2,$0,-3; <instr>; halt...
        vecs[0]  = '{enc_r(1, 2, 3, 6'h20), 3, 32'd2,          15, 32'd3, 1'b0};
        vecs[1]  = '{enc_r(1, 2, 3, 6'h22), 3, 32'd8,          15, 32'd3, 1'b0};
        vecs[2]  = '{enc_r(2, 1, 3, 6'h22), 3, 32'hFFFF_FFF8,  15, 32'd3, 1'b0};
        vecs[3]  = '{enc_r(1, 2, 3, 6'h24), 3, 32'd5,          15, 32'd3, 1'b0};
        vecs[4]  = '{enc_r(1, 2, 3, 6'h25), 3, 32'hFFFF_FFFD,  15, 32'd3, 1'b0};
        vecs[5]  = '{enc_r(2, 1, 5, 6'h2A), 5, 32'd1,          15, 32'd3, 1'b0};
        vecs[6]  = '{enc_r(1, 2, 5, 6'h2A), 5, 32'd0,          15, 32'd3, 1'b0};
        vecs[7]  = '{enc_i(6'h08, 0, 0, 16'd9), 0, 32'd0,      15, 32'd3, 1'b0};
        vecs[8]  = '{enc_i(6'h08, 1, 6, 16'hFFF9), 6, 32'hFFFF_FFFE, 15, 32'd3, 1'b0};
        vecs[9]  = '{enc_i(6'h05, 1, 1, 16'd4), 3, 32'd0,      14, 32'd3, 1'b0};
        vecs[10] = '{enc_i(6'h04, 1, 1, 16'd1), 3, 32'd0,      14, 32'd4, 1'b0};
        vecs[11] = '{enc_j(6'h02, 26'd4), 3, 32'd0,            14, 32'd4, 1'b0};
        vecs[12] = '{enc_r(1, 0, 0, 6'h08), 3, 32'd0,          14, 32'd5, 1'b0};
        vecs[13] = '{enc_r(1, 2, 3, 6'h21), 3, 32'd0,          11, 32'd2, 1'b1};

        // Reset state
        start_reset();
        @(negedge clk);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_we",  {31'd0, mem_we},  32'd0);
        check("reset_halted",  {31'd0, halted},  32'd0);
        check("reset_illegal", {31'd0, illegal}, 32'd0);
        check("reset_pc",      pc_out,           32'd0);

        foreach (vecs[k]) begin
            start_reset();
            mem[0] <= enc_i(6'h08, 0, 1, 16'd5);
            mem[1] <= enc_i(6'h08, 0, 2, 16'hFFFD);
            mem[2] <= vecs[k].instr;
            run(0, 100, cyc);
            check($sformatf("v%0d_reg", k),     rf(vecs[k].reg_idx), vecs[k].exp_val);
            check($sformatf("v%0d_cycles", k),  cyc, vecs[k].exp_cycles);
            check($sformatf("v%0d_pc", k),      pc_out, vecs[k].exp_pc);
            check($sformatf("v%0d_illegal", k), {31'd0, illegal}, {31'd0, vecs[k].exp_ill});
            check($sformatf("v%0d_req_idle", k), {31'd0, mem_req}, 32'd0);
        end

        // sw/lw with 3 wait cycles on every access
        start_reset();
        mem[0] <= enc_i(6'h08, 0, 1, 16'd5);
        mem[1] <= enc_i(6'h2B, 0, 1, 16'd7);
        mem[2] <= enc_i(6'h23, 0, 4, 16'd7);
        mem[7] <= 32'd0;
        run(3, 200, cyc);
        check("ws_mem7",   mem[7], 32'd5);
        check("ws_r4",     rf(4), 32'd5);
        check("ws_cycles", cyc, 32'd34);
        check("ws_stable", viol, 32'd0);
        check("ws_writes", wr_count, 32'd1);

        // beq self-loop at 10
        start_reset();
        mem[0]  <= enc_i(6'h08, 0, 1, 16'd5);
        mem[1]  <= enc_j(6'h02, 26'd10);
        mem[10] <= enc_i(6'h04, 1, 1, 16'hFFFF);
        wait_cycles = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("loop_pc", pc_out, 32'd10);
        check("loop_not_halted", {31'd0, halted}, 32'd0);
        fetch10 <= 0;
        repeat (9) @(negedge clk);
        check("loop_fetches", fetch10, 32'd3);
        check("loop_pc_again", pc_out, 32'd10);

        // jal 0x40 at 3, jr $31 back to 4, addi $0 discarded
        start_reset();
        mem[0]     <= enc_i(6'h08, 0, 1, 16'd5);
        mem[1]     <= enc_i(6'h08, 0, 2, 16'hFFFD);
        mem[2]     <= enc_i(6'h08, 0, 0, 16'd9);
        mem[3]     <= enc_j(6'h03, 26'h40);
        mem[32'h40] <= enc_r(31, 0, 0, 6'h08);
        run(0, 100, cyc);
        check("jal_r31",    rf(31), 32'd4);
        check("jal_r0",     rf(0), 32'd0);
        check("jal_pc",     pc_out, 32'd4);
        check("jal_saw40",  {31'd0, saw40}, 32'd1);
        check("jal_cycles", cyc, 32'd21);

        // Undecoded opcode 0x3E
        start_reset();
        mem[0] <= enc_i(6'h08, 0, 1, 16'd5);
        mem[1] <= enc_i(6'h3E, 1, 7, 16'd3);
        mem[2] <= enc_i(6'h2B, 0, 1, 16'd8);
        mem[8] <= 32'd0;
        run(0, 100, cyc);
        check("ill_flag",   {31'd0, illegal}, 32'd1);
        check("ill_cycles", cyc, 32'd7);
        check("ill_pc",     pc_out, 32'd1);
        check("ill_r7",     rf(7), 32'd0);
        check("ill_r1",     rf(1), 32'd5);
        check("ill_mem8",   mem[8], 32'd0);
        check("ill_writes", wr_count, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("ill_rst_pc",      pc_out, 32'd0);
        check("ill_rst_illegal", {31'd0, illegal}, 32'd0);
        check("ill_rst_halted",  {31'd0, halted}, 32'd0);

        // Reset during a lw memory wait
        start_reset();
        mem[0] <= enc_i(6'h08, 0, 1, 16'd5);
        mem[1] <= enc_i(6'h23, 0, 4, 16'd7);
        mem[7] <= 32'h1234;
        wait_cycles = 5;
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!(mem_req && !mem_we && mem_addr == 32'd7) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mr_reached", {31'd0, mem_req && mem_addr == 32'd7}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_req",   {31'd0, mem_req}, 32'd0);
        check("mr_pc",    pc_out, 32'd0);
        check("mr_state", {29'd0, dut.state}, 32'd0);
        check("mr_r4",    rf(4), 32'd0);
        check("mr_r1",    rf(1), 32'd0);
        run(5, 200, cyc);
        check("mr_rerun_r4",     rf(4), 32'h1234);
        check("mr_rerun_cycles", cyc, 32'd32);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
